// File: rtl/channel_exchanger_pkg.sv
// channel_exchanger_pkg: shared state encoding and width defaults for the channel exchanger
// Contents: xchg_state_t state enum, XFADE_STEPS crossfade weight total, default DATA_W / GAIN_SHIFT.
package channel_exchanger_pkg;
  typedef enum logic [1:0] {SEL_HSNR, XFADE_TO_HDR, SEL_HDR, XFADE_TO_HSNR} xchg_state_t;
  localparam int XFADE_STEPS = 4;
  localparam int DATA_W_DEF = 9;
  localparam int GAIN_SHIFT_DEF = 4;
endpackage

// File: rtl/xfade_mixer.sv
// xfade_mixer: combinational weighted mix (old*(4-k) + new*k) >>> 2, floor rounding
// Ports: old_term/new_term signed OUT_W inputs, k crossfade step 0..3 (0 passes old), mix signed OUT_W result.
import channel_exchanger_pkg::*;
module xfade_mixer #(
  parameter int OUT_W = DATA_W_DEF + GAIN_SHIFT_DEF
) (
  input  logic signed [OUT_W-1:0] old_term,
  input  logic signed [OUT_W-1:0] new_term,
  input  logic        [1:0]       k,
  output logic signed [OUT_W-1:0] mix
);
  localparam logic signed [OUT_W+1:0] FULL = (OUT_W+2)'(XFADE_STEPS);
  logic signed [OUT_W+1:0] kw, acc;
  assign kw = {{OUT_W{1'b0}}, k};
  // two guard bits hold the 4x-scaled weighted sum before the floor shift
  assign acc = old_term * (FULL - kw) + new_term * kw;
  assign mix = OUT_W'(acc >>> $clog2(XFADE_STEPS));
endmodule

// File: rtl/channel_exchanger.sv
// channel_exchanger: debounced HSNR/HDR channel merge into one gain-aligned sample stream
// Ports: clk, reset (async, active-high); in_valid, hsnr_sample, hdr_sample, alpha (1 = HDR),
//        hold_samples (extra mismatches before a switch); out_valid, out_sample, out_sel, switching.
// Macro CHANNEL_EXCHANGER_XFADE_EN enables the 3-step crossfade; otherwise switches are instant.
import channel_exchanger_pkg::*;
module channel_exchanger #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int GAIN_SHIFT = GAIN_SHIFT_DEF,
  localparam int OUT_W = DATA_W + GAIN_SHIFT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] hsnr_sample,
  input  logic signed [DATA_W-1:0] hdr_sample,
  input  logic                     alpha,
  input  logic        [3:0]        hold_samples,
  output logic                     out_valid,
  output logic signed [OUT_W-1:0]  out_sample,
  output logic                     out_sel,
  output logic                     switching
);
  xchg_state_t state, target;
  logic [3:0] cnt;
  logic [1:0] step;
  logic signed [OUT_W-1:0] hs, hd, sel_term, mix;
  logic in_xfade, to_hdr, mismatch, fire;
  assign hs = {{GAIN_SHIFT{hsnr_sample[DATA_W-1]}}, hsnr_sample};
  assign hd = {hdr_sample, {GAIN_SHIFT{1'b0}}};
  assign in_xfade = state == XFADE_TO_HDR || state == XFADE_TO_HSNR;
  // selected channel, or the destination channel while crossfading
  assign to_hdr = state == SEL_HDR || state == XFADE_TO_HDR;
  assign mismatch = alpha != to_hdr;
  assign fire = !in_xfade && mismatch && cnt == hold_samples;
  assign sel_term = to_hdr ? hd : hs;
`ifdef CHANNEL_EXCHANGER_XFADE_EN
  xfade_mixer #(.OUT_W(OUT_W)) u_mix (
    .old_term(to_hdr ? hs : hd),
    .new_term(sel_term),
    .k(step),
    .mix(mix)
  );
  assign target = alpha ? XFADE_TO_HDR : XFADE_TO_HSNR;
`else
  assign mix = sel_term;
  assign target = alpha ? SEL_HDR : SEL_HSNR;
`endif
  // step is nonzero exactly for transition outputs: crossfade weight 1..3,
  // or a one-sample marker after an instant switch when crossfade is off
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= SEL_HSNR;
      cnt <= 4'd0;
      step <= 2'd0;
      out_valid <= 1'b0;
      out_sample <= '0;
      out_sel <= 1'b0;
      switching <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_sample <= in_xfade ? mix : sel_term;
        out_sel <= to_hdr;
        switching <= step != 2'd0;
        if (in_xfade) begin
          step <= step + 2'd1;
          cnt <= 4'd0;
          state <= step == 2'd3 ? (to_hdr ? SEL_HDR : SEL_HSNR) : state;
        end else begin
          step <= fire ? 2'd1 : 2'd0;
          state <= fire ? target : state;
          cnt <= (!mismatch || fire) ? 4'd0 : (cnt == 4'hf ? cnt : cnt + 4'd1);
        end
      end
    end
  end
endmodule

// File: tb/tb_channel_exchanger.sv
// tb_channel_exchanger: scoreboard bench with a sample-level reference model of the channel exchanger
module tb_channel_exchanger;
  localparam int DW = 9;
  localparam int OW = 13;
`ifdef CHANNEL_EXCHANGER_XFADE_EN
  localparam bit XF = 1'b1;
`else
  localparam bit XF = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic alpha = 1'b0;
  logic signed [DW-1:0] hsnr_sample = '0;
  logic signed [DW-1:0] hdr_sample = '0;
  logic [3:0] hold_samples = 4'd0;
  logic out_valid, out_sel, switching;
  logic signed [OW-1:0] out_sample;
  always #5 clk = ~clk;
  channel_exchanger dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .hsnr_sample(hsnr_sample),
    .hdr_sample(hdr_sample),
    .alpha(alpha),
    .hold_samples(hold_samples),
    .out_valid(out_valid),
    .out_sample(out_sample),
    .out_sel(out_sel),
    .switching(switching)
  );
  typedef struct {int v; bit s; bit w;} exp_t;
  exp_t q[$];
  int n_checks = 0;
  int n_fail = 0;
  int m_cur, m_cnt, m_k;
  bit m_pulse;
  bit ra = 1'b0;
  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got %0d expected %0d", name, got, want);
    end
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_out_sample"}, int'(out_sample), 0);
    check({tag, "_out_sel"}, int'(out_sel), 0);
    check({tag, "_switching"}, int'(switching), 0);
  endtask
  function automatic void model_reset();
    m_cur = 0;
    m_cnt = 0;
    m_k = 0;
    m_pulse = 1'b0;
  endfunction
  task automatic scramble();
    hsnr_sample = DW'($urandom);
    hdr_sample = DW'($urandom);
    alpha = 1'($urandom);
  endtask
  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      scramble();
      @(posedge clk);
      #1;
    end
  endtask
  // model: m_cur is the selected (or destination) channel, m_k the crossfade weight of the new channel
  task automatic send(input int hs, input int hd, input bit a);
    exp_t e;
    int old_v, new_v;
    in_valid = 1'b1;
    hsnr_sample = DW'(hs);
    hdr_sample = DW'(hd);
    alpha = a;
    new_v = m_cur != 0 ? hd * 16 : hs;
    old_v = m_cur != 0 ? hs : hd * 16;
    e.s = m_cur != 0;
    e.w = XF ? (m_k != 0) : m_pulse;
    e.v = m_k != 0 ? (old_v * (4 - m_k) + new_v * m_k) >>> 2 : new_v;
    m_pulse = 1'b0;
    if (m_k != 0) begin
      m_k = (m_k + 1) % 4;
      m_cnt = 0;
    end else if (int'(a) == m_cur) m_cnt = 0;
    else if (m_cnt == int'(hold_samples)) begin
      m_cur = int'(a);
      m_cnt = 0;
      if (XF) m_k = 1;
      else m_pulse = 1'b1;
    end else if (m_cnt < 15) m_cnt++;
    q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    scramble();
  endtask
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      n_checks++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output got v=%0d sel=%0b sw=%0b with nothing expected", out_sample, out_sel, switching);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (int'(out_sample) !== e.v || out_sel !== e.s || switching !== e.w) begin
          n_fail++;
          $display("FAIL output got v=%0d sel=%0b sw=%0b expected v=%0d sel=%0b sw=%0b",
                   out_sample, out_sel, switching, e.v, e.s, e.w);
        end
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b0;
    hold_samples = 4'd0;
    repeat (4) send(-5, 7, 1'b0);
    hold_samples = 4'd2;
    repeat (6) send(-5, 3, 1'b1);
    hold_samples = 4'd0;
    repeat (6) send(20, -9, 1'b0);
    hold_samples = 4'd3;
    repeat (2) send(11, 4, 1'b1);
    repeat (5) send(11, 4, 1'b0);
    hold_samples = 4'd0;
    repeat (5) send(100, 10, 1'b1);
    repeat (5) send(100, 10, 1'b0);
    send(100, 10, 1'b1);
    repeat (5) begin
      idle(5);
      send(100, 10, 1'b1);
    end
    repeat (5) send(100, 10, 1'b0);
    repeat (3) send(100, 10, 1'b1);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_zero("mid_xfade_reset");
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (5) send(100, 10, 1'b1);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      if ($urandom_range(0, 19) == 0) hold_samples = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) ra = ~ra;
      send(int'($urandom_range(0, 511)) - 256, int'($urandom_range(0, 511)) - 256, ra);
    end
    idle(3);
    check("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/channel_exchanger.md
# channel_exchanger

Merges the two ADC channels into one output stream, downstream of the HDR/HSNR mode detector. It consumes that block's `alpha` decision (0 = HSNR, 1 = HDR) together with the per-sample HSNR and HDR codes. It debounces `alpha` over a programmable number of samples and scales the HDR code onto the HSNR code scale. It then emits a single gain-aligned sample stream, with an optional crossfade when the channel changes.

## Interface
- `DATA_W`, 9: width of each signed input sample (two's complement).
- `GAIN_SHIFT`, 4: log2 of the HDR-to-HSNR gain ratio.
- `OUT_W`, `DATA_W+GAIN_SHIFT`: output sample width (derived; do not override).
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  sample strobe; inputs are sampled only when high.
- `hsnr_sample`  in  DATA_W  signed HSNR channel code.
- `hdr_sample`  in  DATA_W  signed HDR channel code.
- `alpha`  in  1  requested channel from the mode detector (1 = HDR).
- `hold_samples`  in  4  extra consecutive mismatching valid samples required before a switch (0 = switch on the first).
- `out_valid`  out  1  output sample strobe.
- `out_sample`  out  OUT_W  signed, gain-aligned output sample.
- `out_sel`  out  1  channel used for the current output (1 = HDR).
- `switching`  out  1  high for outputs produced during a channel transition.

## Operation
- Scaling:
  - HSNR term: `hsnr_sample` sign-extended to OUT_W.
  - HDR term: `hdr_sample` sign-extended to OUT_W, then shifted left by GAIN_SHIFT.
  - No saturation is needed; both terms fit in OUT_W.
- States: `SEL_HSNR`, `XFADE_TO_HDR`, `SEL_HDR`, `XFADE_TO_HSNR`. Reset state is `SEL_HSNR`.
- Each valid sample is output using the state held before that sample. State and counter updates take effect from the next valid sample.
- Debounce counter `mismatch_cnt` (4 bits), active in `SEL_*` states only:
  - On a valid sample with `alpha` equal to the current selection: clear the counter.
  - On a valid sample with `alpha` different and `mismatch_cnt == hold_samples`: start the transition and clear the counter.
  - On a valid sample with `alpha` different otherwise: increment the counter. It never exceeds 15.
- In the `XFADE_*` states, `alpha` is ignored and the counter is held at 0.
- When `in_valid` is low: state, counter and `out_sample` hold; `out_valid` is 0.
- `out_sel` reflects the destination channel from the first transition output onward.

## Timing
- Latency: 1 cycle. `out_valid`, `out_sample`, `out_sel` and `switching` are registered, and update the cycle after `in_valid` is high.
- Switch timing: if the first mismatching valid sample is N, the transition begins at valid sample N+1+`hold_samples`.
- Crossfade (macro defined):
  - Transition samples use k = 1, 2, 3: out = (old·(4−k) + new·k) >>> 2.
  - Arithmetic shift, floor rounding; intermediate width is OUT_W+2.
  - `switching` is 1 for those 3 outputs.
  - The 4th valid sample enters `SEL_<new>` and is output from the new channel alone.
- Reset, asserted at any time (including mid-crossfade), clears immediately:
  - state = `SEL_HSNR`, `mismatch_cnt` = 0, crossfade step = 0;
  - `out_valid` = 0, `out_sample` = 0, `out_sel` = 0, `switching` = 0.
- After reset deasserts, the first output takes effect on the first valid sample.
- `alpha` toggling back during the hold period clears the counter; no switch occurs.

## Configuration
- Macro `CHANNEL_EXCHANGER_XFADE_EN`.
- Defined: 3-step crossfade as above, using the `XFADE_*` states.
- Undefined: the `XFADE_*` states are never entered.
  - A transition jumps directly to `SEL_<new>`, so sample N+1+`hold_samples` comes purely from the new channel.
  - `switching` pulses high for that one output only.

## Structure
- `channel_exchanger_pkg`: state enum `xchg_state_t`, `XFADE_STEPS` = 4, and default width constants.
- Sub-module `xfade_mixer`: combinational weighted mix of old/new terms for step k (0–3). k = 0 passes old through. Unused when the macro is undefined.

## Test plan
- Reset then hold `alpha` = 0 with `hsnr_sample` = −5 valid -> `out_sample` = −5, `out_sel` = 0, `switching` = 0, one cycle after each strobe.
- Macro off, `hold_samples` = 2, `alpha` rises at sample 0, `hdr_sample` = 3 -> samples 0–2 from HSNR; sample 3 outputs 48 with `out_sel` = 1 and `switching` high for that one output.
- `hold_samples` = 3, `alpha` high for 2 valid samples, then low -> no switch; counter cleared; `out_sel` stays 0.
- Macro on, old (HSNR) = 100, new (HDR) = 10 (→160), `hold_samples` = 0 -> transition outputs 115, 130, 145 with `switching` = 1, then 160 with `switching` = 0.
- `in_valid` gaps of 5 idle cycles during the crossfade -> `out_valid` low in the gaps; steps advance only on valid samples; values unchanged from the previous case.
- Assert `reset` after crossfade step 2 -> all outputs 0 the same cycle; the next valid sample is output from HSNR with no crossfade.
